// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART receive end-of-frame checker.
// Holds the parity mode encoding, the checker FSM state type and the default
// data width used by uart_frame_chk.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        PARITY,
        STOP1,
        STOP2
    } chk_state_t;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/uart_frame_chk_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, n_rst (async active-low), inc (count one), clr (zero, wins over inc),
//        count (current value, holds at all ones).
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_chk.sv
// End-of-frame checker for the UART receiver: checks the optional parity bit and
// one or two stop bits, one sample strobe at a time, and reports per-frame errors.
// Ports: clk, n_rst (async active-low); chk_start/data_word/parity_mode/two_stop
//        start a check; sample_strobe/sample_bit deliver line samples; err_clear
//        zeroes flags; busy, chk_done, framing_error, parity_error report status.
// Optional: FRAME_CHK_ERR_CNT_EN adds ERR_CNT_W and the err_count saturating counter.
module uart_frame_chk
    import uart_frame_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
`ifdef FRAME_CHK_ERR_CNT_EN
    ,
    parameter int ERR_CNT_W = 8
`endif
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              chk_start,
    input  logic [DATA_W-1:0] data_word,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
    input  logic              sample_strobe,
    input  logic              sample_bit,
    input  logic              err_clear,
    output logic              busy,
    output logic              chk_done,
    output logic              framing_error,
    output logic              parity_error
`ifdef FRAME_CHK_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    chk_state_t state;
    chk_state_t nxt_state;

    logic two_stop_q;
    logic exp_par_q;
    logic par_bad_q;
    logic stop_bad_q;
    logic stop_bad_nxt;
    logic finish;
    logic par_en;

    // The reserved encoding 2'b11 falls through to "no parity".
    assign par_en = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
    assign busy   = (state != IDLE);

    always_comb begin
        nxt_state    = state;
        finish       = 1'b0;
        stop_bad_nxt = stop_bad_q;
        case (state)
            IDLE: begin
                if (chk_start) begin
                    nxt_state = par_en ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (sample_strobe) begin
                    nxt_state = STOP1;
                end
            end
            STOP1: begin
                if (sample_strobe) begin
                    stop_bad_nxt = ~sample_bit;
                    if (two_stop_q) begin
                        nxt_state = STOP2;
                    end else begin
                        nxt_state = IDLE;
                        finish    = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (sample_strobe) begin
                    stop_bad_nxt = stop_bad_q | ~sample_bit;
                    nxt_state    = IDLE;
                    finish       = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            two_stop_q    <= 1'b0;
            exp_par_q     <= 1'b0;
            par_bad_q     <= 1'b0;
            stop_bad_q    <= 1'b0;
            chk_done      <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
        end else begin
            chk_done   <= finish;
            stop_bad_q <= stop_bad_nxt;
            if ((state == IDLE) && chk_start) begin
                two_stop_q <= two_stop;
                exp_par_q  <= (parity_mode == PAR_ODD) ? ~^data_word : ^data_word;
                // Cleared so a no-parity frame never inherits an old parity result.
                par_bad_q  <= 1'b0;
                stop_bad_q <= 1'b0;
            end
            if ((state == PARITY) && sample_strobe) begin
                par_bad_q <= (sample_bit != exp_par_q);
            end
            // Clear beats a simultaneous frame result; chk_done still pulses.
            if (err_clear) begin
                framing_error <= 1'b0;
                parity_error  <= 1'b0;
            end else if (finish) begin
                framing_error <= stop_bad_nxt;
                parity_error  <= par_bad_q;
            end
        end
    end

`ifdef FRAME_CHK_ERR_CNT_EN
    logic err_inc;
    assign err_inc = finish & (stop_bad_nxt | par_bad_q);

    sat_counter #(
        .WIDTH(ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (err_inc),
        .clr   (err_clear),
        .count (err_count)
    );
`endif

endmodule

// File: tb/tb_uart_frame_chk.sv
module tb_uart_frame_chk;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          chk_start;
    logic [DW-1:0] data_word;
    logic [1:0]    parity_mode;
    logic          two_stop;
    logic          sample_strobe;
    logic          sample_bit;
    logic          err_clear;
    logic          busy;
    logic          chk_done;
    logic          framing_error;
    logic          parity_error;
`ifdef FRAME_CHK_ERR_CNT_EN
    logic [CW-1:0] err_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

`ifdef FRAME_CHK_ERR_CNT_EN
    uart_frame_chk #(.DATA_W(DW), .ERR_CNT_W(CW)) dut (
`else
    uart_frame_chk #(.DATA_W(DW)) dut (
`endif
        .clk           (clk),
        .n_rst         (n_rst),
        .chk_start     (chk_start),
        .data_word     (data_word),
        .parity_mode   (parity_mode),
        .two_stop      (two_stop),
        .sample_strobe (sample_strobe),
        .sample_bit    (sample_bit),
        .err_clear     (err_clear),
        .busy          (busy),
        .chk_done      (chk_done),
        .framing_error (framing_error),
        .parity_error  (parity_error)
`ifdef FRAME_CHK_ERR_CNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: counts outstanding strobes, collects the sampled bits,
    // and judges the whole frame once all its bits are in.
    int   m_rem;
    bit   m_bits[$];
    bit   m_par_en, m_two, m_exp;
    bit   m_done, m_fe, m_pe;
    int   m_cnt;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_rem = 0; m_bits.delete(); m_par_en = 0; m_two = 0; m_exp = 0;
            m_done = 0; m_fe = 0; m_pe = 0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                if (sample_strobe) begin
                    m_bits.push_back(sample_bit);
                    m_rem--;
                    if (m_rem == 0) begin
                        bit fe, pe;
                        int nstop;
                        nstop = m_two ? 2 : 1;
                        fe = 0;
                        for (int i = 0; i < nstop; i++)
                            if (m_bits[m_bits.size() - 1 - i] == 0) fe = 1;
                        pe = m_par_en && (m_bits[0] != m_exp);
                        m_done = 1;
                        m_fe = fe;
                        m_pe = pe;
                        if ((fe || pe) && m_cnt < (1 << CW) - 1) m_cnt++;
                    end
                end
            end else if (chk_start) begin
                int ones;
                ones = 0;
                for (int i = 0; i < DW; i++) ones += int'(data_word[i]);
                m_par_en = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                // Parity bit makes the total count of ones even (or odd).
                m_exp = (parity_mode == 2'b10) ? ((ones % 2) == 0) : ((ones % 2) == 1);
                m_two = two_stop;
                m_rem = (m_par_en ? 1 : 0) + (two_stop ? 2 : 1);
                m_bits.delete();
            end
            if (err_clear) begin
                m_fe = 0; m_pe = 0; m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            check("cyc_busy", busy, m_rem != 0);
            check("cyc_done", chk_done, m_done);
            check("cyc_fe", framing_error, m_fe);
            check("cyc_pe", parity_error, m_pe);
`ifdef FRAME_CHK_ERR_CNT_EN
            check("cyc_cnt", err_count, m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] d, input logic [1:0] mode, input logic two);
        chk_start = 1; data_word = d; parity_mode = mode; two_stop = two;
        tick();
        chk_start = 0; data_word = ~d; parity_mode = ~mode; two_stop = ~two;
    endtask

    task automatic strobe(input logic b, input logic clr);
        sample_strobe = 1; sample_bit = b; err_clear = clr;
        tick();
        sample_strobe = 0; sample_bit = ~b; err_clear = 0;
    endtask

    task automatic frame(input logic [7:0] d, input logic [1:0] mode, input logic two,
                         input logic pbit, input logic s1, input logic s2, input logic clr_last);
        start(d, mode, two);
        tick();
        if (mode == 2'b01 || mode == 2'b10) strobe(pbit, 0);
        strobe(s1, clr_last && !two);
        if (two) begin
            tick();
            strobe(s2, clr_last);
        end
    endtask

    task automatic expect_res(input string tag, input logic fe, input logic pe);
        check({tag, "_done"}, chk_done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fe"}, framing_error, fe);
        check({tag, "_pe"}, parity_error, pe);
    endtask

    task automatic expect_cnt(input string tag, input int c);
`ifdef FRAME_CHK_ERR_CNT_EN
        check({tag, "_cnt"}, err_count, c);
`else
        if (c < 0) $display("unused %s", tag);
`endif
    endtask

    initial begin
        n_rst = 0; chk_start = 0; data_word = 0; parity_mode = 0; two_stop = 0;
        sample_strobe = 0; sample_bit = 1; err_clear = 0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", chk_done, 0);
        check("rst_fe", framing_error, 0);
        check("rst_pe", parity_error, 0);
        expect_cnt("rst", 0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1;
        tick();

        // No parity, one stop bit, clean.
        start(8'h3C, 2'b00, 0);
        check("none_busy", busy, 1);
        strobe(1, 0);
        expect_res("none", 0, 0);
        tick();
        check("none_done_once", chk_done, 0);

        // Even parity A5: parity bit 0 is correct, 1 is wrong.
        frame(8'hA5, 2'b01, 1, 0, 1, 1, 0);
        expect_res("even_ok", 0, 0);
        expect_cnt("even_ok", 0);
        frame(8'hA5, 2'b01, 1, 1, 1, 1, 0);
        expect_res("even_bad", 0, 1);
        expect_cnt("even_bad", 1);

        // Odd parity 01 with a bad second stop bit, then a clean frame.
        frame(8'h01, 2'b10, 1, 0, 1, 0, 0);
        expect_res("odd_stop2", 1, 0);
        expect_cnt("odd_stop2", 2);
        frame(8'h01, 2'b10, 1, 0, 1, 1, 0);
        expect_res("odd_clean", 0, 0);

        // Mode 2'b11 is treated as no parity: one strobe completes it.
        frame(8'hFF, 2'b11, 0, 0, 0, 1, 0);
        expect_res("mode3", 1, 0);

        // Clear on its own, then clear coinciding with an errored final strobe.
        err_clear = 1; tick(); err_clear = 0;
        check("clr_fe", framing_error, 0);
        expect_cnt("clr", 0);
        frame(8'h00, 2'b00, 0, 0, 0, 1, 1);
        expect_res("clr_fin", 0, 0);
        expect_cnt("clr_fin", 0);

        // chk_start while busy is ignored.
        start(8'h00, 2'b00, 0);
        start(8'h0F, 2'b01, 1);
        strobe(0, 0);
        expect_res("ign_start", 1, 0);

        // chk_start together with the final strobe is ignored.
        start(8'h00, 2'b00, 0);
        chk_start = 1; parity_mode = 2'b01; two_stop = 1;
        strobe(1, 0);
        chk_start = 0;
        expect_res("same_cyc", 0, 0);
        tick();
        check("same_cyc_idle", busy, 0);

        // Reset in STOP1 after a bad parity bit.
        start(8'hA5, 2'b01, 1);
        strobe(1, 0);
        check("pre_rst_busy", busy, 1);
        #2 n_rst = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", chk_done, 0);
        check("mid_rst_fe", framing_error, 0);
        check("mid_rst_pe", parity_error, 0);
        expect_cnt("mid_rst", 0);
        @(posedge clk);
        #1 n_rst = 1;
        repeat (3) tick();
        frame(8'hA5, 2'b01, 1, 0, 1, 1, 0);
        expect_res("post_rst", 0, 0);

        // Saturation of the error counter over five errored frames.
        for (int i = 0; i < 5; i++) begin
            frame(8'h00, 2'b00, 0, 0, 0, 1, 0);
            expect_res("sat", 1, 0);
            expect_cnt($sformatf("sat%0d", i), (i < 3) ? i + 1 : 3);
        end
        err_clear = 1; tick(); err_clear = 0;
        expect_cnt("sat_clr", 0);
        check("sat_clr_fe", framing_error, 0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
